// File: rtl/tdm_demux_8.sv
// Receive end of an 8-slot TDM link: hunts for the frame sync, collects slots into a
// shadow buffer and publishes each complete frame in parallel with a one-cycle strobe.
module tdm_demux_8 #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] din,
    input  logic         en,
    input  logic         sync,
    output logic [W-1:0] out0,
    output logic [W-1:0] out1,
    output logic [W-1:0] out2,
    output logic [W-1:0] out3,
    output logic [W-1:0] out4,
    output logic [W-1:0] out5,
    output logic [W-1:0] out6,
    output logic [W-1:0] out7,
    output logic         frame_valid,
    output logic         locked,
    output logic         sync_err
);

    localparam int unsigned N_SLOTS = 8;
    localparam int unsigned SLOT_W  = 3;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [W-1:0]      shadow_q [N_SLOTS];
    logic [W-1:0]      shadow_d [N_SLOTS];
    logic [W-1:0]      out_q    [N_SLOTS];
    logic [W-1:0]      out_d    [N_SLOTS];
    logic              frame_valid_q, frame_valid_d;
    logic              sync_err_q, sync_err_d;
    logic              locked_q, locked_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= HUNT;
            slot_q        <= '0;
            shadow_q      <= '{default: '0};
            out_q         <= '{default: '0};
            frame_valid_q <= 1'b0;
            sync_err_q    <= 1'b0;
            locked_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            slot_q        <= slot_d;
            shadow_q      <= shadow_d;
            out_q         <= out_d;
            frame_valid_q <= frame_valid_d;
            sync_err_q    <= sync_err_d;
            locked_q      <= locked_d;
        end
    end

    // Slot capture and framing checks; cycles with en low are not slots at all.
    always_comb begin
        state_d       = state_q;
        slot_d        = slot_q;
        shadow_d      = shadow_q;
        out_d         = out_q;
        frame_valid_d = 1'b0;
        sync_err_d    = 1'b0;

        if (en) begin
            case (state_q)
                HUNT: begin
                    if (sync) begin
                        shadow_d[0] = din;
                        slot_d      = SLOT_W'(1);
                        state_d     = LOCKED;
                    end
                end
                LOCKED: begin
                    if (sync) begin
                        // Early sync restarts the frame here; partial data is simply overwritten.
                        sync_err_d  = (slot_q != '0);
                        shadow_d[0] = din;
                        slot_d      = SLOT_W'(1);
                    end else if (slot_q == '0) begin
                        sync_err_d = 1'b1;
                        state_d    = HUNT;
                    end else if (slot_q == SLOT_W'(N_SLOTS - 1)) begin
                        for (int unsigned i = 0; i < N_SLOTS - 1; i++) begin
                            out_d[i] = shadow_q[i];
                        end
                        out_d[N_SLOTS-1] = din;
                        frame_valid_d    = 1'b1;
                        slot_d           = '0;
                    end else begin
                        shadow_d[slot_q] = din;
                        slot_d           = slot_q + SLOT_W'(1);
                    end
                end
                default: state_d = HUNT;
            endcase
        end

        locked_d = (state_d == LOCKED);
    end

    assign out0        = out_q[0];
    assign out1        = out_q[1];
    assign out2        = out_q[2];
    assign out3        = out_q[3];
    assign out4        = out_q[4];
    assign out5        = out_q[5];
    assign out6        = out_q[6];
    assign out7        = out_q[7];
    assign frame_valid = frame_valid_q;
    assign sync_err    = sync_err_q;
    assign locked      = locked_q;

endmodule

// File: tb/tb_tdm_demux_8.sv
// Self-checking bench for tdm_demux_8: directed frame scenarios plus randomized traffic
// compared every cycle against a queue-based frame model.
module tb_tdm_demux_8;

    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] din;
    logic         en;
    logic         sync;
    logic [W-1:0] out0, out1, out2, out3, out4, out5, out6, out7;
    logic         frame_valid, locked, sync_err;

    int errors = 0;
    int checks = 0;

    tdm_demux_8 #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .en(en), .sync(sync),
        .out0(out0), .out1(out1), .out2(out2), .out3(out3),
        .out4(out4), .out5(out5), .out6(out6), .out7(out7),
        .frame_valid(frame_valid), .locked(locked), .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    // Reference model: a link either hunting or locked, with the slots of the frame in progress.
    logic         m_locked;
    logic [W-1:0] m_frame [$];
    logic [W-1:0] m_out [8];
    logic         m_fv, m_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_locked = 1'b0;
        m_frame.delete();
        for (int i = 0; i < 8; i++) m_out[i] = '0;
        m_fv  = 1'b0;
        m_err = 1'b0;
    endtask

    task automatic model_step(input logic e, input logic s, input logic [W-1:0] d);
        m_fv  = 1'b0;
        m_err = 1'b0;
        if (!e) return;
        if (!m_locked) begin
            if (s) begin
                m_frame.delete();
                m_frame.push_back(d);
                m_locked = 1'b1;
            end
        end else if (s) begin
            m_err = (m_frame.size() != 0);
            m_frame.delete();
            m_frame.push_back(d);
        end else if (m_frame.size() == 0) begin
            m_err    = 1'b1;
            m_locked = 1'b0;
        end else begin
            m_frame.push_back(d);
            if (m_frame.size() == 8) begin
                for (int i = 0; i < 8; i++) m_out[i] = m_frame[i];
                m_fv = 1'b1;
                m_frame.delete();
            end
        end
    endtask

    task automatic compare_all(input string where);
        logic [W-1:0] got [8];
        got = '{out0, out1, out2, out3, out4, out5, out6, out7};
        for (int i = 0; i < 8; i++) check($sformatf("%s out%0d", where, i), 32'(got[i]), 32'(m_out[i]));
        check({where, " frame_valid"}, 32'(frame_valid), 32'(m_fv));
        check({where, " sync_err"}, 32'(sync_err), 32'(m_err));
        check({where, " locked"}, 32'(locked), 32'(m_locked));
        check({where, " fv_and_err"}, 32'(frame_valid & sync_err), 32'(0));
    endtask

    task automatic cycle(input string where, input logic e, input logic s, input logic [W-1:0] d);
        @(negedge clk);
        en = e; sync = s; din = d;
        @(posedge clk);
        model_step(e, s, d);
        #1;
        compare_all(where);
    endtask

    // Sends one frame of 8 enabled slots; idle cycles inserted between slots when gap is set.
    task automatic send_frame(input string where, input logic [W-1:0] v [8], input bit gap);
        for (int i = 0; i < 8; i++) begin
            cycle(where, 1'b1, i == 0, v[i]);
            if (gap) cycle({where, " idle"}, 1'b0, 1'b0, W'($urandom));
        end
    endtask

    task automatic async_reset_pulse(input string where);
        @(negedge clk);
        #2 rst_n = 1'b0;
        model_reset();
        #1 compare_all({where, " in_reset"});
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [W-1:0] pat_a [8];
    logic [W-1:0] pat_b [8];
    int           phase;
    int           fv_cycle;
    logic         s_r;

    initial begin
        pat_a = '{W'(1), W'(0), W'(1), W'(1), W'(0), W'(0), W'(1), W'(0)};
        for (int i = 0; i < 8; i++) pat_b[i] = W'(pat_a[i] ^ 1);
        en = 1'b0; sync = 1'b0; din = '0;
        rst_n = 1'b0;
        model_reset();
        #12;
        compare_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Single frame, then back-to-back inverted frame with strobe timing tracked.
        send_frame("frame1", pat_a, 1'b0);
        check("frame1 fv_seen", 32'(frame_valid), 32'(1));
        fv_cycle = 0;
        for (int i = 0; i < 8; i++) begin
            cycle("frame2", 1'b1, i == 0, pat_b[i]);
            if (frame_valid) fv_cycle = i + 1;
        end
        check("frame2 fv_cycle", 32'(fv_cycle), 32'(8));
        check("frame2 out0", 32'(out0), 32'(pat_b[0]));
        cycle("after_frame2", 1'b0, 1'b0, '0);

        // Enable toggling across a frame.
        send_frame("en_gap", pat_a, 1'b1);

        // Early sync at slot 4, then completion from the new slot 0.
        for (int i = 0; i < 4; i++) cycle("early_pre", 1'b1, i == 0, pat_b[i]);
        cycle("early_sync", 1'b1, 1'b1, W'(9));
        check("early sync_err", 32'(sync_err), 32'(1));
        check("early locked", 32'(locked), 32'(1));
        for (int i = 1; i < 8; i++) cycle("early_post", 1'b1, 1'b0, W'(i + 8));
        check("early fv", 32'(frame_valid), 32'(1));
        check("early out7", 32'(out7), 32'(15));

        // Missing sync after a good frame, then relock.
        cycle("miss_sync", 1'b1, 1'b0, W'(3));
        check("miss locked", 32'(locked), 32'(0));
        cycle("hunt_idle", 1'b1, 1'b0, W'(5));
        send_frame("relock", pat_b, 1'b0);

        // Asynchronous reset at slot 3.
        for (int i = 0; i < 3; i++) cycle("pre_rst", 1'b1, i == 0, W'($urandom));
        async_reset_pulse("mid_rst");
        for (int i = 0; i < 5; i++) cycle("post_rst_tail", 1'b1, 1'b0, W'($urandom));
        send_frame("post_rst", pat_a, 1'b0);

        // Randomized traffic with occasional framing faults and idle cycles.
        phase = 0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                cycle("rand_idle", 1'b0, $urandom_range(0, 1) == 1, W'($urandom));
            end else begin
                s_r = (phase == 0);
                if ($urandom_range(0, 29) == 0) s_r = ~s_r;
                if (s_r) phase = 0;
                cycle("rand", 1'b1, s_r, W'($urandom));
                phase = (phase + 1) % 8;
            end
            if (n == 1500) async_reset_pulse("rand_rst");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
